// File: rtl/uart_word_tx_arbiter.sv
// uart_word_tx_arbiter: round-robin arbiter that shares one byte-wide UART
// transmitter among NUM_REQ requesters and sends each granted W_D-bit word
// least-significant byte first over the transmitter's WE/READY handshake.
//
// Parameters:
//   NUM_REQ    number of requesters (1..8)
//   W_D        word width in bits (multiple of 8)
//
// Ports:
//   CLK         clock
//   RST         synchronous, active-high reset
//   REQ         level request per requester
//   REQ_DATA    word of requester i at [i*W_D +: W_D], sampled at grant only
//   GRANT       one-hot, requester currently being served
//   DONE        one-cycle pulse once the served word's last byte has left
//   BUSY        high whenever the FSM is not idle
//   UART_DATA   byte presented to the transmitter
//   UART_WE     write enable to the transmitter
//   UART_READY  transmitter idle flag
//
// Optional feature (macro UART_ARB_HEADER_EN): each word is preceded by a
// header byte 8'hA0 | requester index, sent with the same handshake.

module uart_word_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int W_D     = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [NUM_REQ*W_D-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic [NUM_REQ-1:0]     DONE,
    output logic                   BUSY,
    output logic [7:0]             UART_DATA,
    output logic                   UART_WE,
    input  logic                   UART_READY
);

    localparam int BYTES = W_D / 8;
`ifdef UART_ARB_HEADER_EN
    localparam int NBYTES = BYTES + 1;
`else
    localparam int NBYTES = BYTES;
`endif
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(NBYTES + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);
    localparam logic [IW:0]   NREQ     = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_HOLD,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [W_D-1:0]     buf_q, buf_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               we_q, we_d;
    logic [7:0]         data_q, data_d;

    // Round-robin pick: first set REQ bit scanning upward from ptr_q.
    // cand is one bit wider so ptr + offset can wrap without overflow.
    logic [IW:0]   cand;
    logic          win_found;
    logic [IW-1:0] win_idx;

    always_comb begin
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IW + 1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && REQ[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Byte selection: the header byte, when present, occupies slot 0 and
    // does not consume the shift buffer.
    logic [7:0] tx_byte;
    logic       shift_en;

`ifdef UART_ARB_HEADER_EN
    logic       hdr_slot;
    assign hdr_slot = (cnt_q == '0);
    assign tx_byte  = hdr_slot ? (8'hA0 | 8'(idx_q)) : buf_q[7:0];
    assign shift_en = !hdr_slot;
`else
    assign tx_byte  = buf_q[7:0];
    assign shift_en = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        we_d    = we_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    buf_d            = REQ_DATA[int'(win_idx) * W_D +: W_D];
                    idx_d            = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    cnt_d            = '0;
                    busy_d           = 1'b1;
                    state_d          = S_SEND;
                end
            end
            S_SEND: begin
                if (UART_READY) begin
                    we_d    = 1'b1;
                    data_d  = tx_byte;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // READY falling means the transmitter has taken the byte.
                if (!UART_READY) begin
                    we_d  = 1'b0;
                    cnt_d = cnt_q + CW'(1);
                    if (shift_en) begin
                        buf_d = buf_q >> 8;
                    end
                    state_d = (cnt_q == LAST_CNT) ? S_FIN : S_SEND;
                end
            end
            S_FIN: begin
                // READY rising again means the last stop bit is out.
                if (UART_READY) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            data_q  <= data_d;
        end
    end

    assign GRANT     = grant_q;
    assign DONE      = done_q;
    assign BUSY      = busy_q;
    assign UART_WE   = we_q;
    assign UART_DATA = data_q;

endmodule

// File: tb/tb_uart_word_tx_arbiter.sv
// tb_uart_word_tx_arbiter: scoreboard bench for uart_word_tx_arbiter with a
// transmitter model, requester agents and a round-robin reference model.

module tb_uart_word_tx_arbiter;

    localparam int NUM_REQ = 2;
    localparam int W_D     = 32;
    localparam int BYTES   = W_D / 8;
    localparam int MAXW    = 4;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic [NUM_REQ-1:0]     REQ = '0;
    logic [NUM_REQ*W_D-1:0] REQ_DATA = '0;
    logic [NUM_REQ-1:0]     GRANT;
    logic [NUM_REQ-1:0]     DONE;
    logic                   BUSY;
    logic [7:0]             UART_DATA;
    logic                   UART_WE;
    logic                   UART_READY = 1'b1;

    uart_word_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .W_D    (W_D)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_DATA  (REQ_DATA),
        .GRANT     (GRANT),
        .DONE      (DONE),
        .BUSY      (BUSY),
        .UART_DATA (UART_DATA),
        .UART_WE   (UART_WE),
        .UART_READY(UART_READY)
    );

    always #5 CLK = ~CLK;

    logic [7:0]     exp_bytes[$];
    int             exp_done[$];
    int             checks   = 0;
    int             failures = 0;
    int             nbytes   = 0;
    int             go_seq   = 0;
    int             long_seq = 0;
    int             mptr     = 0;
    int             wcnt[NUM_REQ];
    logic [W_D-1:0] wrd[NUM_REQ][MAXW];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=nothing", name, act);
    endtask

    // Reference model: every pending requester holds REQ until its last
    // word is done, so service is plain round-robin over remaining counts.
    task automatic plan();
        int             rem[NUM_REQ];
        int             pos[NUM_REQ];
        int             total;
        int             c;
        int             j;
        logic [W_D-1:0] w;
        total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = wcnt[i];
            pos[i] = 0;
            total += wcnt[i];
        end
        while (total > 0) begin
            c = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (mptr + k) % NUM_REQ;
                if (c < 0 && rem[j] > 0) c = j;
            end
            w = wrd[c][pos[c]];
`ifdef UART_ARB_HEADER_EN
            exp_bytes.push_back(8'hA0 | 8'(c));
`endif
            for (int b = 0; b < BYTES; b++) begin
                exp_bytes.push_back(w[8*b +: 8]);
            end
            exp_done.push_back(c);
            pos[c]++;
            rem[c]--;
            total--;
            mptr = (c + 1) % NUM_REQ;
        end
        go_seq++;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_done.size() != 0 || exp_bytes.size() != 0 || BUSY)
               && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 5000) begin
            fail_now({name, "_timeout"}, 64'(exp_done.size()));
            exp_done.delete();
            exp_bytes.delete();
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic rand_words();
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < MAXW; k++) wrd[i][k] = $urandom;
        end
    endtask

    // Transmitter model, requester agents and output monitor.
    initial begin : agent
        logic               rdy;
        logic               we_prev;
        logic [NUM_REQ-1:0] gprev;
        int                 busy;
        int                 seen_go;
        int                 seen_long;
        bit                 long_pend;
        bit                 lat;
        int                 wrem[NUM_REQ];
        int                 wpos[NUM_REQ];
        rdy = 1'b1; we_prev = 1'b0; gprev = '0; busy = 0;
        seen_go = 0; seen_long = 0; long_pend = 0; lat = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wrem[i] = 0;
            wpos[i] = 0;
        end
        forever begin
            @(negedge CLK);
            if (UART_WE && !we_prev) chk("we_needs_ready", 64'(rdy), 1);
            if (rdy && UART_WE) begin
                nbytes++;
                if (exp_bytes.size() == 0) fail_now("unexpected_byte", 64'(UART_DATA));
                else chk("uart_byte", 64'(UART_DATA), 64'(exp_bytes.pop_front()));
                rdy  = 1'b0;
                busy = long_pend ? 50 : int'($urandom_range(2, 6));
                long_pend = 0;
            end else if (!rdy) begin
                if (busy > 0) busy--;
                else rdy = 1'b1;
            end
            if (long_seq != seen_long) begin
                seen_long = long_seq;
                long_pend = 1;
            end
            we_prev    = UART_WE;
            UART_READY = rdy;

            if (RST) begin
                REQ   = '0;
                gprev = '0;
                lat   = 0;
                for (int i = 0; i < NUM_REQ; i++) wrem[i] = 0;
            end else begin
                if (lat) begin
                    chk("grant_latency", 64'(GRANT != 0), 1);
                    lat = 0;
                end
                if (GRANT != 0 && gprev == 0) begin
                    chk("grant_onehot", 64'($onehot(GRANT)), 1);
                    chk("busy_with_grant", 64'(BUSY), 1);
                    if (exp_done.size() == 0) fail_now("unexpected_grant", 64'(GRANT));
                    else chk("grant_index", 64'(GRANT), 64'(1) << exp_done[0]);
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (GRANT[i]) REQ_DATA[i*W_D +: W_D] = $urandom;
                    end
                end
                if (DONE != 0) begin
                    chk("done_follows_grant", 64'(DONE), 64'(gprev));
                    chk("grant_clear_at_done", 64'(GRANT), 0);
                    chk("busy_clear_at_done", 64'(BUSY), 0);
                    chk("done_after_frame", 64'(rdy), 1);
                    if (exp_done.size() == 0) fail_now("unexpected_done", 64'(DONE));
                    else chk("done_index", 64'(DONE), 64'(1) << exp_done.pop_front());
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (DONE[i] && wrem[i] > 0) begin
                            wrem[i]--;
                            wpos[i]++;
                            if (wrem[i] > 0) REQ_DATA[i*W_D +: W_D] = wrd[i][wpos[i]];
                            else REQ[i] = 1'b0;
                        end
                    end
                end
                if (go_seq != seen_go) begin
                    seen_go = go_seq;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        wrem[i] = wcnt[i];
                        wpos[i] = 0;
                        REQ[i]  = (wcnt[i] > 0);
                        if (wcnt[i] > 0) REQ_DATA[i*W_D +: W_D] = wrd[i][0];
                    end
                    lat = 1;
                end
                gprev = GRANT;
            end
        end
    end

    initial begin : main
        int n0;
        int n;
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        chk("reset_grant", 64'(GRANT), 0);
        chk("reset_done", 64'(DONE), 0);
        chk("reset_busy", 64'(BUSY), 0);
        chk("reset_we", 64'(UART_WE), 0);
        chk("reset_data", 64'(UART_DATA), 0);
        RST = 1'b0;
        @(negedge CLK);

        wcnt = '{2, 1};
        wrd[0][0] = 32'hAAAA0001;
        wrd[0][1] = 32'hAAAA0001;
        wrd[1][0] = 32'hBBBB0002;
        plan();
        wait_drain("contention");

        wcnt = '{1, 0};
        wrd[0][0] = 32'h12345678;
        plan();
        wait_drain("single");

        wcnt = '{0, 1};
        wrd[1][0] = 32'h00000005;
        plan();
        wait_drain("req1_small");

        long_seq++;
        wcnt = '{1, 1};
        rand_words();
        plan();
        wait_drain("backpressure");

        wcnt = '{1, 0};
        rand_words();
        n0 = nbytes;
        plan();
        n = 0;
        while (nbytes < n0 + 2 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) fail_now("midword_timeout", 64'(nbytes - n0));
        RST = 1'b1;
        exp_bytes.delete();
        exp_done.delete();
        mptr = 0;
        @(negedge CLK);
        chk("midrst_we", 64'(UART_WE), 0);
        chk("midrst_grant", 64'(GRANT), 0);
        chk("midrst_busy", 64'(BUSY), 0);
        chk("midrst_done", 64'(DONE), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        wcnt = '{1, 1};
        rand_words();
        plan();
        wait_drain("after_reset");

        repeat (25) begin
            for (int i = 0; i < NUM_REQ; i++) wcnt[i] = int'($urandom_range(0, 3));
            if (wcnt[0] == 0 && wcnt[1] == 0) wcnt[$urandom_range(0, 1)] = 1;
            rand_words();
            plan();
            wait_drain("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
